// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch time base.
// Commands, FSM states and the decade digit limit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        CTRL_NONE  = 2'd0,
        CTRL_START = 2'd1,
        CTRL_PAUSE = 2'd2,
        CTRL_STOP  = 2'd3
    } sw_ctrl_t;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_COUNTING = 2'd1,
        ST_PAUSED   = 2'd2
    } sw_state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/tick_decade.sv
// One BCD decade of the tick cascade.
// Advances on en_in and passes a carry on 9 -> 0.
module tick_decade
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en_in,
    output logic [3:0] digit,
    output logic       en_out
);

    logic at_max;

    assign at_max = (digit == DIGIT_MAX);
    assign en_out = en_in && at_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (en_in) begin
            digit <= at_max ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_tick_gen.sv
// Stopwatch time base: prescaler plus cascaded decades.
// Optional BCD phase output under STOPWATCH_PHASE_EN.
module stopwatch_tick_gen
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BASE_HZ = 1000,
    parameter int N_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         ctrl,
    output logic [N_TICKS-1:0] tick,
    output logic [1:0]         state,
    output logic               running
`ifdef STOPWATCH_PHASE_EN
    ,
    output logic [4*(N_TICKS-1)-1:0] phase
`endif
);

    localparam int DIV   = CLK_HZ / BASE_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_MAX =
        PRE_W'(DIV - 1);

    sw_state_t          state_q;
    sw_state_t          state_d;
    sw_ctrl_t           cmd;
    logic               counting;
    logic               clr;
    logic [PRE_W-1:0]   pre;
    logic [N_TICKS-1:0] wrap;

    assign cmd      = sw_ctrl_t'(ctrl);
    assign counting = (state_q == ST_COUNTING);
    assign state    = state_q;
    assign running  = counting;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOPPED: begin
                if (cmd == CTRL_START)
                    state_d = ST_COUNTING;
            end
            ST_COUNTING: begin
                if (cmd == CTRL_PAUSE)
                    state_d = ST_PAUSED;
                else if (cmd == CTRL_STOP)
                    state_d = ST_STOPPED;
            end
            ST_PAUSED: begin
                if (cmd == CTRL_START)
                    state_d = ST_COUNTING;
                else if (cmd == CTRL_STOP)
                    state_d = ST_STOPPED;
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // Anything heading to STOPPED wipes the phase and any tick.
    assign clr     = (state_d == ST_STOPPED);
    assign wrap[0] = counting && (pre == PRE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (counting) begin
            pre <= wrap[0] ? '0 : pre + PRE_W'(1);
        end
    end

    for (genvar k = 1; k < N_TICKS; k++) begin : g_dec
        tick_decade u_dec (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .en_in  (wrap[k-1]),
`ifdef STOPWATCH_PHASE_EN
            .digit  (phase[4*k-4 +: 4]),
`else
            .digit  (),
`endif
            .en_out (wrap[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick <= '0;
        end else begin
            tick <= clr ? '0 : wrap;
        end
    end

endmodule

// File: tb/tb_stopwatch_tick_gen.sv
// Directed bench for stopwatch_tick_gen (DIV=10, 3 ticks).
// Phase checks build only with STOPWATCH_PHASE_EN.
module tb_stopwatch_tick_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] ctrl = 2'd0;
    logic [2:0] tick;
    logic [1:0] state;
    logic       running;
`ifdef STOPWATCH_PHASE_EN
    logic [7:0] phase;
`endif

    stopwatch_tick_gen #(
        .CLK_HZ  (10_000),
        .BASE_HZ (1000),
        .N_TICKS (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (ctrl),
        .tick    (tick),
        .state   (state),
        .running (running)
`ifdef STOPWATCH_PHASE_EN
        ,
        .phase   (phase)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] c;
        logic [1:0] st;
    } vec_t;

    vec_t tbl [11];

    int total = 0;
    int bad   = 0;
    int mst   = 0;
    int mcnt  = 0;
    logic [2:0] mtick = '0;
    int n0 = 0;
    int n1 = 0;
    int n2 = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h",
                     nm, act, exp);
        end
    endtask

    // Behavioural view: ticks follow total counting cycles.
    task automatic model(input logic [1:0] c);
        mtick = '0;
        case (mst)
            1: begin
                if (c == 2'd3) begin
                    mst  = 0;
                    mcnt = 0;
                end else begin
                    mcnt++;
                    mtick[0] = (mcnt % 10 == 0);
                    mtick[1] = (mcnt % 100 == 0);
                    mtick[2] = (mcnt % 1000 == 0);
                    if (c == 2'd2) mst = 2;
                end
            end
            2: begin
                if (c == 2'd1) begin
                    mst = 1;
                end else if (c == 2'd3) begin
                    mst  = 0;
                    mcnt = 0;
                end
            end
            default: if (c == 2'd1) mst = 1;
        endcase
    endtask

    task automatic cyc(input logic [1:0] c,
                       input string nm);
        ctrl = c;
        @(posedge clk);
        model(c);
        #1;
        chk({nm, ".tick"}, 32'(tick), 32'(mtick));
        chk({nm, ".state"}, 32'(state), 32'(mst));
        chk({nm, ".run"}, 32'(running),
            32'(mst == 1));
        n0 += int'(tick[0]);
        n1 += int'(tick[1]);
        n2 += int'(tick[2]);
    endtask

    task automatic run(input int n,
                       input logic [1:0] c,
                       input string nm);
        for (int i = 0; i < n; i++) cyc(c, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        tbl[0]  = '{2'd2, 2'd0};
        tbl[1]  = '{2'd3, 2'd0};
        tbl[2]  = '{2'd0, 2'd0};
        tbl[3]  = '{2'd1, 2'd1};
        tbl[4]  = '{2'd1, 2'd1};
        tbl[5]  = '{2'd2, 2'd2};
        tbl[6]  = '{2'd2, 2'd2};
        tbl[7]  = '{2'd0, 2'd2};
        tbl[8]  = '{2'd3, 2'd0};
        tbl[9]  = '{2'd1, 2'd1};
        tbl[10] = '{2'd3, 2'd0};

        #12;
        chk("rst.tick", 32'(tick), 0);
        chk("rst.state", 32'(state), 0);
        chk("rst.run", 32'(running), 0);
`ifdef STOPWATCH_PHASE_EN
        chk("rst.phase", 32'(phase), 0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].c, "tbl");
            chk("tbl.vec_state", 32'(state),
                32'(tbl[i].st));
            chk("tbl.vec_tick", 32'(tick), 0);
        end

        // Free run, with redundant STARTs sprinkled in.
        cyc(2'd1, "free");
        n0 = 0; n1 = 0; n2 = 0;
        for (int i = 1; i <= 1000; i++)
            cyc((i % 7 == 0) ? 2'd1 : 2'd0, "free");
        chk("free.last", 32'(tick), 32'h7);
        chk("free.n0", 32'(n0), 100);
        chk("free.n1", 32'(n1), 10);
        chk("free.n2", 32'(n2), 1);
        cyc(2'd3, "free");

        // Pause after 37 counting cycles, hold 50.
        cyc(2'd1, "pause");
        run(36, 2'd0, "pause");
        cyc(2'd2, "pause");
        run(50, 2'd0, "pause");
        cyc(2'd1, "pause");
        cyc(2'd0, "pause");
        cyc(2'd0, "pause");
        chk("pause.t39", 32'(tick), 0);
        cyc(2'd0, "pause");
        chk("pause.t40", 32'(tick), 32'h1);

        // Stop at counting cycle 55, then restart.
        cyc(2'd3, "stop");
        cyc(2'd1, "stop");
        run(54, 2'd0, "stop");
        cyc(2'd3, "stop");
        chk("stop.state", 32'(state), 0);
        cyc(2'd1, "stop");
        first = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(2'd0, "stop");
            if (tick[0] && first == 0) first = i;
        end
        chk("stop.first", 32'(first), 10);
        chk("stop.t100", 32'(tick), 32'h3);

        // Asynchronous reset while a tick is high.
        #2 rst = 1'b0;
        #1;
        chk("arst.tick", 32'(tick), 0);
        chk("arst.state", 32'(state), 0);
        chk("arst.run", 32'(running), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        mst = 0; mcnt = 0;
        run(20, 2'd0, "arst");
        cyc(2'd1, "arst");
        run(12, 2'd0, "arst");

        // STOP while paused clears the held phase.
        cyc(2'd3, "pstop");
        cyc(2'd1, "pstop");
        run(5, 2'd0, "pstop");
        cyc(2'd2, "pstop");
        cyc(2'd3, "pstop");
        chk("pstop.state", 32'(state), 0);
        cyc(2'd1, "pstop");
        run(12, 2'd0, "pstop");

`ifdef STOPWATCH_PHASE_EN
        cyc(2'd3, "phase");
        cyc(2'd1, "phase");
        run(249, 2'd0, "phase");
        cyc(2'd2, "phase");
        chk("phase.p250", 32'(phase), 32'h25);
        run(20, 2'd0, "phase");
        chk("phase.hold", 32'(phase), 32'h25);
        cyc(2'd3, "phase");
        chk("phase.stop", 32'(phase), 0);
`endif

        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_tick_gen.md
# stopwatch_tick_gen

Parametrised stopwatch time base that produces a chain of decade-spaced, single-cycle tick strobes (base period, ×10, ×100, …) under START/PAUSE/STOP control. It is the generalised successor of the fixed four-channel stopwatch timer. It sits between the button/control decoder and the stopwatch display counters. Unlike the fixed version, it has:

- registered strobes with exact periods;
- a configurable clock, base rate and channel count;
- a shared prescaler feeding cascaded decade stages instead of independent wide counters.

## Interface

Parameters:

- CLK_HZ, 50_000_000: input clock frequency.
- BASE_HZ, 1000: rate of tick[0]. CLK_HZ must be an exact multiple of BASE_HZ. DIV = CLK_HZ/BASE_HZ, DIV ≥ 2.
- N_TICKS, 4: number of tick channels, 1..8. tick[k] period = 10^k base periods.

Ports:

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ctrl  in  2  command, sampled every cycle: 0 NONE, 1 START, 2 PAUSE, 3 STOP.
- tick  out  N_TICKS  one-cycle strobes, registered.
- state  out  2  current state: 0 STOPPED, 1 COUNTING, 2 PAUSED.
- running  out  1  high when state == COUNTING.
- phase  out  4*(N_TICKS-1)  BCD decade digits, present only with STOPWATCH_PHASE_EN.

## Operation

- **Prescaler:**
  - Width $clog2(DIV); counts 0..DIV-1 while COUNTING.
  - wrap0 = COUNTING && pre == DIV-1. On wrap0, pre returns to 0.
- **Decade stages:**
  - Stage k (1..N_TICKS-1) is a 4-bit counter 0..9 that advances on wrap(k-1).
  - wrap(k) = wrap(k-1) && dec[k] == 9.
  - The next-state register is tick[k] <= wrap(k). All active strobes are therefore coincident with tick[0].
- **STOPPED:**
  - pre, all decades and tick are 0.
  - START → COUNTING. PAUSE and NONE are ignored.
- **COUNTING:**
  - Counters advance every cycle.
  - PAUSE → PAUSED. That cycle still counts and may emit ticks.
  - STOP → STOPPED. Counters clear at that edge and no tick is emitted from that cycle.
  - START and NONE: stay in COUNTING.
- **PAUSED:**
  - Counters hold and tick stays 0.
  - START → COUNTING, continuing from the held phase.
  - STOP → STOPPED with counters cleared.
  - PAUSE and NONE are ignored.
- **Encoding:** state 3 is unreachable and recovers to STOPPED on the next edge.
- **Width:** no arithmetic overflow is possible. The top decade wraps 9 → 0 and emits tick[N_TICKS-1].

## Timing

- **Reset values:** tick = 0, state = STOPPED, running = 0, phase = 0, all counters = 0. Reset is applied immediately (asynchronous) and releases synchronously to the next edge.
- **START latency:** START sampled at edge E puts the block in COUNTING after E. The first tick[0] is high in the cycle following edge E+DIV.
- **Tick periods:** tick[0] repeats every DIV cycles while counting uninterrupted. tick[k] repeats every DIV·10^k cycles. Pulse width is exactly 1 cycle.
- **Pause accounting:** pauses do not count. A tick occurs after the same total number of COUNTING cycles as if no pause had happened.
- **Reset mid-operation:** abandons all phase. A new START is required to resume counting.

## Configuration

STOPWATCH_PHASE_EN:

- **Defined:** the phase output exists. It is the concatenation of dec[N_TICKS-1]..dec[1], most-significant digit first. It is combinationally driven from the decade registers, holds in PAUSED and clears on STOP or reset.
- **Undefined:** the port is absent. Tick behaviour is identical.

## Structure

- **Package stopwatch_pkg:**
  - ctrl encodings CTRL_NONE/START/PAUSE/STOP;
  - state encodings ST_STOPPED/COUNTING/PAUSED;
  - DIGIT_MAX = 9.
- **Sub-module tick_decade:** one instance per decade stage. Inputs clk, rst, clr, en_in. Outputs digit[3:0] and en_out = en_in && digit == 9. Instantiated by a generate loop.

## Test plan

All scenarios use CLK_HZ = 10_000, BASE_HZ = 1000 (DIV = 10), N_TICKS = 3.

- **Free run:** reset, then START for 1 cycle → tick[0] at COUNTING cycles 10, 20, …; tick[1] at 100, 200; tick[2] at 1000. Strobes are coincident and exactly 1 cycle wide.
- **Pause/resume:** PAUSE after 37 COUNTING cycles, hold 50 cycles, then START → no ticks during the pause; next tick[0] after 3 further COUNTING cycles (40 total).
- **Stop/restart:** STOP at COUNTING cycle 55, then START → state goes STOPPED; first tick[0] 10 cycles after re-entry to COUNTING; tick[1] after 100.
- **Asynchronous reset:** rst low mid-count → tick = 0, state = STOPPED and running = 0 immediately; no counting until START.
- **Ignored commands:**
  - START while counting → no phase change.
  - PAUSE while STOPPED → stays STOPPED.
  - STOP while PAUSED → STOPPED with counters cleared.
- **STOPWATCH_PHASE_EN:** 250 COUNTING cycles then PAUSE → phase = {4'd2, 4'd5}, holding while paused; STOP → phase = 0.
